// File: rtl/branch_history_table.sv
// -----------------------------------------------------------------------------
// branch_history_table
//
// Parametrised branch-direction predictor: a table of 2^INDEX_BITS saturating
// counters. After reset an initialisation sweep writes every entry to
// weakly-not-taken, and only then is the table accepting updates.
//
// Optional feature macro: BHT_GSHARE_EN
//   defined   -> lookup index = lookup_pc[INDEX_BITS:1] XOR zero-extended ghr
//   undefined -> lookup index = lookup_pc[INDEX_BITS:1]
//   In both builds ghr is shifted on every accepted update and output.
//
// Ports:
//   clk              in   single clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   lookup_pc        in   fetch PC (16 bits)
//   pred_taken       out  predicted direction (MSB of the indexed counter)
//   pred_index       out  table index used for the lookup
//   ready            out  initialisation sweep done, updates accepted
//   upd_valid        in   resolved-branch update strobe
//   upd_index        in   index carried from pred_index
//   upd_taken        in   actual branch outcome
//   upd_mispredict   in   resolve stage flags the prediction as wrong
//   ghr              out  global history register (newest outcome in bit 0)
//   mispredict_count out  saturating 16-bit count of mispredicted updates
//
// Assumes 2 <= GHR_BITS <= INDEX_BITS <= 14 and CTR_WIDTH >= 2.
// -----------------------------------------------------------------------------
module branch_history_table #(
  parameter int INDEX_BITS = 6,
  parameter int CTR_WIDTH  = 2,
  parameter int GHR_BITS   = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           lookup_pc,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  output logic                  ready,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  output logic [GHR_BITS-1:0]   ghr,
  output logic [15:0]           mispredict_count
);

  localparam int DEPTH = 1 << INDEX_BITS;

  localparam logic [CTR_WIDTH-1:0]  CTR_WNT  = {1'b0, {(CTR_WIDTH-1){1'b1}}};
  localparam logic [CTR_WIDTH-1:0]  CTR_MAX  = {CTR_WIDTH{1'b1}};
  localparam logic [CTR_WIDTH-1:0]  CTR_MIN  = '0;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = {INDEX_BITS{1'b1}};

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]            state;
  logic [INDEX_BITS-1:0] init_ptr;
  logic [CTR_WIDTH-1:0]  ctr_table [DEPTH];

  logic [INDEX_BITS-1:0] pc_index;
  logic                  upd_en;
  logic [CTR_WIDTH-1:0]  upd_ctr;
  logic [CTR_WIDTH-1:0]  upd_ctr_next;

  // PC bit 0 and the bits above the index field never take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[15:INDEX_BITS+1], lookup_pc[0]};

  // ---------------------------------------------------------------------------
  // Lookup path (fully combinational, reads the pre-update table contents)
  // ---------------------------------------------------------------------------
  assign pc_index = lookup_pc[INDEX_BITS:1];

`ifdef BHT_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_pad;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path can leave it holding its old value (which would infer a latch).
  always_comb begin
    ghr_pad                 = '0;
    ghr_pad[GHR_BITS-1:0]   = ghr;
    pred_index              = pc_index ^ ghr_pad;
  end
`else
  assign pred_index = pc_index;
`endif

  assign ready      = (state == ST_READY);
  assign pred_taken = ready & ctr_table[pred_index][CTR_WIDTH-1];

  // ---------------------------------------------------------------------------
  // Saturating counter update
  // ---------------------------------------------------------------------------
  assign upd_en  = ready & upd_valid;
  assign upd_ctr = ctr_table[upd_index];

  always_comb begin
    upd_ctr_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + 1'b1;
    end else begin
      if (upd_ctr != CTR_MIN) upd_ctr_next = upd_ctr - 1'b1;
    end
  end

  // NOTE: the counter array has no reset; the post-reset sweep initialises it
  // one entry per cycle, which keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      ctr_table[init_ptr] <= CTR_WNT;
    end else if (upd_en) begin
      ctr_table[upd_index] <= upd_ctr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state, global history and mispredict counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_INIT;
      init_ptr         <= '0;
      ghr              <= '0;
      mispredict_count <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          // Updates arriving during the sweep are dropped entirely.
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == LAST_IDX) state <= ST_READY;
        end
        default: begin
          if (upd_valid) begin
            ghr <= {ghr[GHR_BITS-2:0], upd_taken};
            if (upd_mispredict && (mispredict_count != 16'hFFFF)) begin
              mispredict_count <= mispredict_count + 16'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_history_table.sv
// -----------------------------------------------------------------------------
// tb_branch_history_table
//
// Self-checking bench for branch_history_table at default parameters.
// Table of update/lookup vectors with expected predictions before and after the
// clock edge; post-edge expectations go through a scoreboard queue. Hand-written
// sequences cover the initialisation sweep, gshare indexing and reset mid-run.
// -----------------------------------------------------------------------------
module tb_branch_history_table;

  localparam int IB = 6;
  localparam int GB = 6;

  logic          clk;
  logic          reset_n;
  logic [15:0]   lookup_pc;
  logic          pred_taken;
  logic [IB-1:0] pred_index;
  logic          ready;
  logic          upd_valid;
  logic [IB-1:0] upd_index;
  logic          upd_taken;
  logic          upd_mispredict;
  logic [GB-1:0] ghr;
  logic [15:0]   mispredict_count;

  branch_history_table #(.INDEX_BITS(IB), .CTR_WIDTH(2), .GHR_BITS(GB)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .lookup_pc        (lookup_pc),
    .pred_taken       (pred_taken),
    .pred_index       (pred_index),
    .ready            (ready),
    .upd_valid        (upd_valid),
    .upd_index        (upd_index),
    .upd_taken        (upd_taken),
    .upd_mispredict   (upd_mispredict),
    .ghr              (ghr),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [IB-1:0] idx;
    logic          taken;
    logic          mis;
    logic          exp_pre;
    logic          exp_post;
  } vec_t;

  typedef struct {
    logic [IB-1:0] idx;
    logic          pred;
    logic [GB-1:0] ghr;
    logic [15:0]   cnt;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  logic [GB-1:0] m_ghr = '0;
  logic [15:0]   m_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // PC whose lookup lands on table index idx under the bench's view of ghr.
  function automatic logic [15:0] pc_for(input logic [IB-1:0] idx);
    logic [IB-1:0] raw;
    raw = idx;
`ifdef BHT_GSHARE_EN
    raw = idx ^ m_ghr;
`endif
    return {9'b0, raw, 1'b0};
  endfunction

  task automatic apply_vec(input vec_t v);
    exp_t e;
    @(negedge clk);
    upd_valid      = v.valid;
    upd_index      = v.idx;
    upd_taken      = v.taken;
    upd_mispredict = v.mis;
    lookup_pc      = pc_for(v.idx);
    #1;
    check("pred_index", 32'(pred_index), 32'(v.idx));
    check("pred_pre", 32'(pred_taken), 32'(v.exp_pre));
    if (v.valid) begin
      m_ghr = {m_ghr[GB-2:0], v.taken};
      if (v.mis && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    sb.push_back('{idx: v.idx, pred: v.exp_post, ghr: m_ghr, cnt: m_cnt});
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    e = sb.pop_front();
    lookup_pc = pc_for(e.idx);
    #1;
    check("pred_post", 32'(pred_taken), 32'(e.pred));
    check("ghr", 32'(ghr), 32'(e.ghr));
    check("mispredict_count", 32'(mispredict_count), 32'(e.cnt));
  endtask

  // Releases reset with a junk update held high; expects ready after exactly
  // 64 edges and an untouched ghr/count, then every entry weakly not-taken.
  task automatic do_sweep();
    @(negedge clk);
    upd_valid      = 1'b1;
    upd_index      = 6'd3;
    upd_taken      = 1'b1;
    upd_mispredict = 1'b1;
    reset_n        = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("ready_edge%0d", i), 32'(ready), (i == 64) ? 32'd1 : 32'd0);
    end
    upd_valid = 1'b0;
    m_ghr = '0;
    m_cnt = '0;
    check("ghr_after_init", 32'(ghr), 32'd0);
    check("count_after_init", 32'(mispredict_count), 32'd0);
    for (int i = 0; i < 64; i++) begin
      lookup_pc = pc_for(6'(i));
      #0.1;
      check($sformatf("init_entry%0d", i), 32'(pred_taken), 32'd0);
    end
  endtask

  vec_t vecs[24];

  initial begin
    // valid idx taken mis pre post
    vecs[0]  = '{1'b0, 6'd6,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 6'd5,  1'b1, 1'b0, 1'b0, 1'b1}; // 01->10
    vecs[2]  = '{1'b1, 6'd5,  1'b1, 1'b0, 1'b1, 1'b1}; // 10->11
    vecs[3]  = '{1'b1, 6'd5,  1'b1, 1'b0, 1'b1, 1'b1}; // 11->11
    vecs[4]  = '{1'b1, 6'd5,  1'b1, 1'b0, 1'b1, 1'b1}; // 11->11
    vecs[5]  = '{1'b1, 6'd5,  1'b0, 1'b0, 1'b1, 1'b1}; // 11->10
    vecs[6]  = '{1'b1, 6'd5,  1'b0, 1'b0, 1'b1, 1'b0}; // 10->01
    vecs[7]  = '{1'b1, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0}; // 01->00
    vecs[8]  = '{1'b1, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0}; // 00->00
    vecs[9]  = '{1'b1, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0}; // 00->00
    vecs[10] = '{1'b1, 6'd9,  1'b1, 1'b0, 1'b0, 1'b1}; // same-cycle lookup
    vecs[11] = '{1'b0, 6'd6,  1'b0, 1'b0, 1'b0, 1'b0}; // neighbour untouched
    vecs[12] = '{1'b0, 6'd9,  1'b0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 6'd20, 1'b0, 1'b0, 1'b0, 1'b0}; // 01->00
    vecs[14] = '{1'b1, 6'd20, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 6'd20, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 6'd20, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 6'd20, 1'b1, 1'b0, 1'b0, 1'b0}; // 00->01
    vecs[18] = '{1'b1, 6'd20, 1'b1, 1'b0, 1'b0, 1'b1}; // 01->10, ghr=000011
    vecs[19] = '{1'b1, 6'd30, 1'b1, 1'b1, 1'b0, 1'b1}; // mispredicts
    vecs[20] = '{1'b1, 6'd30, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 6'd30, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 6'd30, 1'b0, 1'b0, 1'b1, 1'b1};

    reset_n        = 1'b0;
    lookup_pc      = 16'h0000;
    upd_valid      = 1'b0;
    upd_index      = '0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
    #12;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_ghr", 32'(ghr), 32'd0);
    check("rst_count", 32'(mispredict_count), 32'd0);
    check("rst_pred", 32'(pred_taken), 32'd0);
    lookup_pc = 16'h0010;
    #1;
    check("rst_pred_index", 32'(pred_index), 32'h08);

    do_sweep();

    for (int i = 0; i < 24; i++) begin
      apply_vec(vecs[i]);
      if (i == 18) begin
        check("ghr_pattern", 32'(ghr), 32'h03);
        lookup_pc = 16'h0010;
        #1;
`ifdef BHT_GSHARE_EN
        check("gshare_index", 32'(pred_index), 32'h0B);
`else
        check("plain_index", 32'(pred_index), 32'h08);
`endif
      end
    end
    check("count_three", 32'(mispredict_count), 32'd3);

    // Reset asserted mid-stream while an update is being presented.
    @(negedge clk);
    upd_valid      = 1'b1;
    upd_index      = 6'd30;
    upd_taken      = 1'b1;
    upd_mispredict = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("midop_count", 32'(mispredict_count), 32'd0);
    check("midop_ready", 32'(ready), 32'd0);
    check("midop_ghr", 32'(ghr), 32'd0);
    check("midop_pred", 32'(pred_taken), 32'd0);
    upd_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Release, then pull reset again partway through the sweep.
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midinit_ready", 32'(ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check("midinit_ghr", 32'(ghr), 32'd0);
    repeat (2) @(posedge clk);

    do_sweep();
    // Entry 5 was driven to 00 earlier; a full re-sweep brings it back to 01.
    apply_vec('{1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1});
    apply_vec('{1'b0, 6'd20, 1'b0, 1'b0, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
